// File: rtl/ebc.sv
// External bus controller: turns arbiter requests into single-beat or line-burst
// transactions on the 64-bit memory bus. Optional watchdog: EBC_TIMEOUT_EN.
`ifndef CMEM_LINE
`define CMEM_LINE 256
`endif

module ebc #(
  parameter int LINE_W  = `CMEM_LINE,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       c_addr,
  input  logic              c_ext,
  input  logic              c_rd,
  input  logic              c_wr,
  input  logic [1:0]        c_len,
  input  logic [63:0]       c_wdata,
  output logic [LINE_W-1:0] c_rdata,
  output logic              c_dv,
  output logic              c_err,
  output logic              m_req,
  input  logic              m_ack,
  output logic [63:0]       m_addr,
  output logic              m_rd,
  output logic              m_wr,
  output logic [1:0]        m_len,
  output logic              m_burst,
  output logic [63:0]       m_wdata,
  input  logic              m_rvalid,
  input  logic [63:0]       m_rdata,
  input  logic              m_wack,
  output logic [2:0]        dbg_state
);

  localparam int BEATS = LINE_W / 64;
  localparam int K_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFS_W = $clog2(LINE_W / 8);

  if ((LINE_W % 64) != 0 || LINE_W < 64 || LINE_W > 1024 || TIMEOUT < 1) begin : g_bad_params
    $error("ebc: unsupported LINE_W or TIMEOUT");
  end

  // Handshake: m_req rises with all m_* fields valid and holds them stable until
  // the first cycle with m_ack=1; read beats are taken on m_rvalid, a write
  // completes on m_wack, and c_dv pulses once per request with c_err qualifying it.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RBEAT = 3'd2,
    S_WRESP = 3'd3,
    S_DONE  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t         state;
  logic [K_W-1:0] k;
  logic           is_wr;
  logic           line_rd;
  logic           last_beat;
  logic           expired;

  assign dbg_state = state;
  assign last_beat = !line_rd || (k == K_W'(BEATS - 1));

`ifdef EBC_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] wd_cnt;

  // Restarts whenever the bus shows progress, so only a stalled phase expires.
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE || state == S_DONE || state == S_GAP) begin
      wd_cnt <= '0;
    end else if ((state == S_REQ && m_ack) || (state == S_RBEAT && m_rvalid)) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign expired = (wd_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      k       <= '0;
      is_wr   <= 1'b0;
      line_rd <= 1'b0;
      c_rdata <= '0;
      c_dv    <= 1'b0;
      c_err   <= 1'b0;
      m_req   <= 1'b0;
      m_addr  <= '0;
      m_rd    <= 1'b0;
      m_wr    <= 1'b0;
      m_len   <= '0;
      m_burst <= 1'b0;
      m_wdata <= '0;
    end else begin
      c_dv  <= 1'b0;
      c_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (c_wr || c_rd) begin
            state   <= S_REQ;
            is_wr   <= c_wr;
            line_rd <= !c_wr && !c_ext;
            m_req   <= 1'b1;
            m_rd    <= !c_wr;
            m_wr    <= c_wr;
            m_wdata <= c_wr ? c_wdata : 64'd0;
            if (!c_wr && !c_ext) begin
              m_addr  <= {c_addr[63:OFS_W], {OFS_W{1'b0}}};
              m_len   <= 2'd3;
              m_burst <= 1'b1;
            end else begin
              m_addr  <= c_addr;
              m_len   <= c_len;
              m_burst <= 1'b0;
            end
          end
        end
        S_REQ: begin
          if (m_ack || expired) begin
            m_req   <= 1'b0;
            m_addr  <= '0;
            m_rd    <= 1'b0;
            m_wr    <= 1'b0;
            m_len   <= '0;
            m_burst <= 1'b0;
            m_wdata <= '0;
          end
          if (m_ack) begin
            state <= is_wr ? S_WRESP : S_RBEAT;
          end else if (expired) begin
            state <= S_DONE;
            c_dv  <= 1'b1;
            c_err <= 1'b1;
            if (!is_wr) c_rdata <= '0;
          end
        end
        S_RBEAT: begin
          if (m_rvalid) begin
            // The first beat of a read also clears the rest of the line.
            if (k == '0) begin
              c_rdata <= LINE_W'(m_rdata);
            end else begin
              for (int i = 1; i < BEATS; i++) begin
                if (k == K_W'(i)) c_rdata[i*64 +: 64] <= m_rdata;
              end
            end
            if (last_beat) begin
              k     <= '0;
              state <= S_DONE;
              c_dv  <= 1'b1;
            end else begin
              k <= k + 1'b1;
            end
          end else if (expired) begin
            k       <= '0;
            c_rdata <= '0;
            state   <= S_DONE;
            c_dv    <= 1'b1;
            c_err   <= 1'b1;
          end
        end
        S_WRESP: begin
          if (m_wack) begin
            state <= S_DONE;
            c_dv  <= 1'b1;
          end else if (expired) begin
            state <= S_DONE;
            c_dv  <= 1'b1;
            c_err <= 1'b1;
          end
        end
        S_DONE:  state <= S_GAP;
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
